// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared types and constants for the hazard control unit
// FSM encoding, XZR default and control-bundle bit positions shared with the pipeline top.
package hazard_control_unit_pkg;

   typedef enum logic [0:0] {
      ST_IDLE       = 1'b0,
      ST_LOAD_STALL = 1'b1
   } hcu_state_e;

   localparam int ZERO_REG_DEFAULT = 31;
   localparam int REM_W            = 4;

   // Control bundle layout, also used by the pipeline top to unpack the bundle
   localparam int CTL_PC_WE      = 5;
   localparam int CTL_IFID_WE    = 4;
   localparam int CTL_BUBBLE     = 3;
   localparam int CTL_IFID_FLUSH = 2;
   localparam int CTL_IDEX_FLUSH = 1;
   localparam int CTL_FREEZE     = 0;
   localparam int CTL_W          = 6;

   function automatic logic [CTL_W-1:0] ctl_default();
      logic [CTL_W-1:0] c;
      c = '0;
      c[CTL_PC_WE]   = 1'b1;
      c[CTL_IFID_WE] = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - saturating up-counter with synchronous clear
// Clear wins over hold but a same-cycle increment still counts, so clear+inc yields 1.
module hazard_sat_counter #(
   parameter int STAT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              inc_i,
   input  logic              clr_i,
   output logic [STAT_W-1:0] count_o
);

   logic [STAT_W-1:0] count_q;
   logic [STAT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = STAT_W'(inc_i);
      end else if (inc_i && (count_q != {STAT_W{1'b1}})) begin
         count_d = count_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush and memory freeze control
// Outputs are combinational from FSM state and inputs; priority is mem_busy > branch_taken > load-use.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int REG_ADDR_W      = 5,
   parameter int ZERO_REG        = ZERO_REG_DEFAULT,
   parameter int LOAD_USE_STALLS = 1,
   parameter int STAT_W          = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic [REG_ADDR_W-1:0] if_id_rn,
   input  logic [REG_ADDR_W-1:0] if_id_rm,
   input  logic                  if_id_uses_rn,
   input  logic                  if_id_uses_rm,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   input  logic                  stat_clear,
   output logic                  pc_write_en,
   output logic                  if_id_write_en,
   output logic                  id_ex_bubble,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  pipe_freeze,
   output logic [STAT_W-1:0]     stall_count
);

   if ((LOAD_USE_STALLS < 1) || (LOAD_USE_STALLS > 15)) begin : g_bad_stalls
      $error("hazard_control_unit: LOAD_USE_STALLS must be in 1..15");
   end

   localparam logic [REG_ADDR_W-1:0] ZERO_SPEC = REG_ADDR_W'(ZERO_REG);
   localparam logic [REM_W-1:0]      REM_INIT  = REM_W'(LOAD_USE_STALLS - 1);

   hcu_state_e       state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [CTL_W-1:0] ctl;
   logic             hazard;
   logic             stall;

   assign hazard = id_ex_mem_read && (id_ex_rd != ZERO_SPEC) &&
                   ((if_id_uses_rn && (id_ex_rd == if_id_rn)) ||
                    (if_id_uses_rm && (id_ex_rd == if_id_rm)));

   always_comb begin
      ctl     = ctl_default();
      state_d = state_q;
      rem_d   = rem_q;
      stall   = 1'b0;
      // Combinational outputs must not react to inputs while reset is held
      if (!reset) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else if (mem_busy) begin
         ctl[CTL_FREEZE]  = 1'b1;
         ctl[CTL_PC_WE]   = 1'b0;
         ctl[CTL_IFID_WE] = 1'b0;
      end else if (branch_taken) begin
         ctl[CTL_IFID_FLUSH] = 1'b1;
         ctl[CTL_IDEX_FLUSH] = 1'b1;
         state_d             = ST_IDLE;
         rem_d               = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (hazard) begin
                  stall = 1'b1;
                  if (LOAD_USE_STALLS > 1) begin
                     state_d = ST_LOAD_STALL;
                     rem_d   = REM_INIT;
                  end
               end
            end
            ST_LOAD_STALL: begin
               stall = 1'b1;
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end
         endcase
      end

      if (stall) begin
         ctl[CTL_PC_WE]   = 1'b0;
         ctl[CTL_IFID_WE] = 1'b0;
         ctl[CTL_BUBBLE]  = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   hazard_sat_counter #(
      .STAT_W (STAT_W)
   ) u_stat (
      .clk_i   (clock),
      .rst_ni  (reset),
      .inc_i   (stall),
      .clr_i   (stat_clear),
      .count_o (stall_count)
   );

   assign pc_write_en    = ctl[CTL_PC_WE];
   assign if_id_write_en = ctl[CTL_IFID_WE];
   assign id_ex_bubble   = ctl[CTL_BUBBLE];
   assign if_id_flush    = ctl[CTL_IFID_FLUSH];
   assign id_ex_flush    = ctl[CTL_IDEX_FLUSH];
   assign pipe_freeze    = ctl[CTL_FREEZE];

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
// Three instances (1, 3 and 2 bubbles; last one with a 4-bit counter) share one stimulus stream.
module tb_hazard_control_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic       ld;
   logic [4:0] rd, rn, rm;
   logic       urn, urm, br, mb, clr;

   wire [5:0]  c0, c1, c2;
   wire [15:0] cnt0, cnt1;
   wire [3:0]  cnt2;

   int n_checks = 0;
   int n_err    = 0;

   int lus  [3] = '{1, 3, 2};
   int cmax [3] = '{65535, 65535, 15};
   int pend [3];
   int cnt  [3];

   always #5 clock = ~clock;

   hazard_control_unit #(.REG_ADDR_W(5), .ZERO_REG(31), .LOAD_USE_STALLS(1), .STAT_W(16)) dut_l1 (
      .clock(clock), .reset(reset), .id_ex_mem_read(ld), .id_ex_rd(rd), .if_id_rn(rn), .if_id_rm(rm),
      .if_id_uses_rn(urn), .if_id_uses_rm(urm), .branch_taken(br), .mem_busy(mb), .stat_clear(clr),
      .pc_write_en(c0[5]), .if_id_write_en(c0[4]), .id_ex_bubble(c0[3]), .if_id_flush(c0[2]),
      .id_ex_flush(c0[1]), .pipe_freeze(c0[0]), .stall_count(cnt0));

   hazard_control_unit #(.REG_ADDR_W(5), .ZERO_REG(31), .LOAD_USE_STALLS(3), .STAT_W(16)) dut_l3 (
      .clock(clock), .reset(reset), .id_ex_mem_read(ld), .id_ex_rd(rd), .if_id_rn(rn), .if_id_rm(rm),
      .if_id_uses_rn(urn), .if_id_uses_rm(urm), .branch_taken(br), .mem_busy(mb), .stat_clear(clr),
      .pc_write_en(c1[5]), .if_id_write_en(c1[4]), .id_ex_bubble(c1[3]), .if_id_flush(c1[2]),
      .id_ex_flush(c1[1]), .pipe_freeze(c1[0]), .stall_count(cnt1));

   hazard_control_unit #(.REG_ADDR_W(5), .ZERO_REG(31), .LOAD_USE_STALLS(2), .STAT_W(4)) dut_sat (
      .clock(clock), .reset(reset), .id_ex_mem_read(ld), .id_ex_rd(rd), .if_id_rn(rn), .if_id_rm(rm),
      .if_id_uses_rn(urn), .if_id_uses_rm(urm), .branch_taken(br), .mem_busy(mb), .stat_clear(clr),
      .pc_write_en(c2[5]), .if_id_write_en(c2[4]), .id_ex_bubble(c2[3]), .if_id_flush(c2[2]),
      .id_ex_flush(c2[1]), .pipe_freeze(c2[0]), .stall_count(cnt2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] obs_ctl(input int i);
      case (i)
         0:       return c0;
         1:       return c1;
         default: return c2;
      endcase
   endfunction

   function automatic logic [31:0] obs_cnt(input int i);
      case (i)
         0:       return {16'd0, cnt0};
         1:       return {16'd0, cnt1};
         default: return {28'd0, cnt2};
      endcase
   endfunction

   task automatic drive(input logic l, input logic [4:0] d, input logic [4:0] n, input logic [4:0] m,
                        input logic un, input logic um, input logic b, input logic busy, input logic c);
      ld = l; rd = d; rn = n; rm = m; urn = un; urm = um; br = b; mb = busy; clr = c;
   endtask

   // One clock: called at a falling edge with inputs already driven.
   task automatic cycle();
      logic       haz;
      logic [5:0] e;
      logic       st [3];
      #2;
      haz = ld && (rd != 5'd31) && ((urn && rd == rn) || (urm && rd == rm));
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         e     = 6'b110000;
         if (!reset) begin
            pend[i] = 0;
            cnt[i]  = 0;
         end else if (mb) begin
            e = 6'b000001;
         end else if (br) begin
            e = 6'b110110;
         end else if (pend[i] > 0 || haz) begin
            st[i] = 1'b1;
            e     = 6'b001000;
         end
         check($sformatf("ctl[%0d]", i), {26'd0, obs_ctl(i)}, {26'd0, e});
         check($sformatf("count[%0d]", i), obs_cnt(i), cnt[i]);
      end
      @(posedge clock);
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            if (!mb) begin
               if (br)               pend[i] = 0;
               else if (pend[i] > 0) pend[i] = pend[i] - 1;
               else if (haz)         pend[i] = lus[i] - 1;
            end
            if (clr)                            cnt[i] = st[i] ? 1 : 0;
            else if (st[i] && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         cycle();
      end
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   task automatic hazard_x3();
      drive(1, 5'd3, 5'd3, 5'd4, 1, 1, 0, 0, 0);
      cycle();
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin pend[i] = 0; cnt[i] = 0; end
      @(negedge clock);
      cycle();
      reset = 1'b1;

      // Single load-use pulse: 1, 3 and 2 bubbles respectively
      hazard_x3();
      idle(4);
      check("t1_cnt_l1", {16'd0, cnt0}, 32'd1);
      check("t1_cnt_l3", {16'd0, cnt1}, 32'd3);
      check("t1_cnt_l2", {28'd0, cnt2}, 32'd2);

      // XZR destination and unused rm never stall
      do_reset();
      drive(1, 5'd31, 5'd31, 5'd0, 1, 0, 0, 0, 0); cycle();
      drive(1, 5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 0);   cycle();
      idle(3);
      check("t2_cnt_l3", {16'd0, cnt1}, 32'd0);

      // Branch on second stall cycle abandons the remaining bubbles
      do_reset();
      hazard_x3();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
      idle(4);
      check("t4_cnt_l3", {16'd0, cnt1}, 32'd1);
      check("t4_cnt_l2", {28'd0, cnt2}, 32'd1);

      // mem_busy for 4 cycles stretches but does not shorten the stall
      do_reset();
      hazard_x3();
      for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(); end
      idle(5);
      check("t5_cnt_l3", {16'd0, cnt1}, 32'd3);
      check("t5_cnt_l1", {16'd0, cnt0}, 32'd1);

      // Saturation of the 4-bit counter, clear, then reset during a stall
      do_reset();
      for (int k = 0; k < 20; k++) begin hazard_x3(); idle(3); end
      check("t6_sat", {28'd0, cnt2}, 32'd15);
      check("t6_cnt_l1", {16'd0, cnt0}, 32'd20);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
      check("t6_clr", {28'd0, cnt2}, 32'd0);
      hazard_x3();
      reset = 1'b0;
      drive(1, 5'd3, 5'd3, 5'd4, 1, 1, 0, 0, 0); cycle();
      reset = 1'b1;
      idle(3);
      check("t6_post_reset", {16'd0, cnt1}, 32'd0);

      // Randomized traffic against the reference model
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         logic [4:0] d, n, m;
         logic       busy;
         d    = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 6));
         n    = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 6));
         m    = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 6));
         busy = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 1) == 1, d, n, m, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) == 0, busy, !busy && ($urandom_range(0, 29) == 0));
         reset = ($urandom_range(0, 199) != 0);
         cycle();
      end
      reset = 1'b1;
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
